montgomery_sequencer: RTL

- Sequences one shared carry-select adder, with start/done/subtract/shift ports, through bit-serial Montgomery multiplication.
- Computes result = in_a * in_b * 2^(-WIDTH) mod in_m.
- Owns the accumulator C and all operand multiplexing. The adder is instantiated beside it, and its adder-side ports connect one-to-one.
- Sits between the RSA exponentiation control and the adder.

---
 rtl/montgomery_sequencer_if.sv | 35 +++
 rtl/montgomery_sequencer.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/montgomery_sequencer_if.sv
// Bus bundle for montgomery_sequencer: the host request/response signals
// (start, operands, result, done, busy) and the adder-side handshake
// (add_start/subtract/shift, operands, result, add_done).
// The master modport is the sequencer's view; slave is the environment's
// view (host plus the shared carry-select adder).
interface montgomery_sequencer_if #(
  parameter int WIDTH = 512
);
  logic             start;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [WIDTH-1:0] in_m;
  logic [WIDTH-1:0] result;
  logic             done;
  logic             busy;
  logic             add_start;
  logic             add_subtract;
  logic             add_shift;
  logic [WIDTH+1:0] add_in_a;
  logic [WIDTH+1:0] add_in_b;
  logic [WIDTH+2:0] add_result;
  logic             add_done;

  modport master (
    input  start, in_a, in_b, in_m, add_result, add_done,
    output result, done, busy, add_start, add_subtract, add_shift,
           add_in_a, add_in_b
  );

  modport slave (
    output start, in_a, in_b, in_m, add_result, add_done,
    input  result, done, busy, add_start, add_subtract, add_shift,
           add_in_a, add_in_b
  );
endinterface

// File: rtl/montgomery_sequencer.sv
// Bit-serial Montgomery multiplier sequencer: result = a*b*2^(-WIDTH) mod m.
// Drives one external carry-select adder through the add/reduce/shift loop,
// owning the accumulator C and all operand multiplexing.
// Optional feature macro SHIFT_FUSE_EN: the modulus add requests a
// shift-on-latch from the adder so the separate SHIFT cycle is skipped
// on odd-C bits.
module montgomery_sequencer #(
  parameter int WIDTH = 512,
  parameter int CNTW  = 9
) (
  input logic                  clk,
  input logic                  reset,
  montgomery_sequencer_if.master bus
);

  typedef enum logic [3:0] {
    IDLE, ADD_B, WAIT_B, ADD_M, WAIT_M, SHIFT, SUB, WAIT_SUB, DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, m_q, m_d;
  logic [WIDTH+1:0] c_q, c_d;
  logic [CNTW-1:0]  i_q, i_d;
  logic [WIDTH-1:0] result_q, result_d;

  logic             add_start_s;
  logic             add_sub_s;
  logic             add_shift_s;
  logic [WIDTH+1:0] add_in_b_s;
  logic             a_bit;
  logic             last_bit;

  // Current multiplier bit selected by the loop counter, and last-bit flag
  assign a_bit    = |(a_q & (WIDTH'(1) << i_q));
  assign last_bit = (i_q == CNTW'(WIDTH - 1));

  // Next-state and adder request decode
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    m_d         = m_q;
    c_d         = c_q;
    i_d         = i_q;
    result_d    = result_q;
    add_start_s = 1'b0;
    add_sub_s   = 1'b0;
    add_shift_s = 1'b0;
    add_in_b_s  = '0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = bus.in_a;
          b_d     = bus.in_b;
          m_d     = bus.in_m;
          c_d     = '0;
          i_d     = '0;
          state_d = ADD_B;
        end
      end
      ADD_B: begin
        if (a_bit) begin
          add_start_s = 1'b1;
          add_in_b_s  = {2'b00, b_q};
          state_d     = WAIT_B;
        end else begin
          state_d = ADD_M;
        end
      end
      WAIT_B: begin
        if (bus.add_done) begin
          c_d     = bus.add_result[WIDTH+1:0];
          state_d = ADD_M;
        end
      end
      ADD_M: begin
        if (c_q[0]) begin
          add_start_s = 1'b1;
          add_in_b_s  = {2'b00, m_q};
`ifdef SHIFT_FUSE_EN
          add_shift_s = 1'b1;
`endif
          state_d     = WAIT_M;
        end else begin
          state_d = SHIFT;
        end
      end
      WAIT_M: begin
        if (bus.add_done) begin
          c_d = bus.add_result[WIDTH+1:0];
`ifdef SHIFT_FUSE_EN
          // Adder already returned (C+M)>>1, so this bit is complete
          if (last_bit) begin
            state_d = SUB;
          end else begin
            i_d     = i_q + CNTW'(1);
            state_d = ADD_B;
          end
`else
          state_d = SHIFT;
`endif
        end
      end
      SHIFT: begin
        c_d = c_q >> 1;
        if (last_bit) begin
          state_d = SUB;
        end else begin
          i_d     = i_q + CNTW'(1);
          state_d = ADD_B;
        end
      end
      SUB: begin
        // C - M as C + ~M + 1 over WIDTH+2 bits
        add_start_s = 1'b1;
        add_sub_s   = 1'b1;
        add_in_b_s  = ~{2'b00, m_q};
        state_d     = WAIT_SUB;
      end
      WAIT_SUB: begin
        if (bus.add_done) begin
          // C < 2M, so a clear bit WIDTH+1 means C >= M and C-M is final
          if (!bus.add_result[WIDTH+1]) begin
            result_d = bus.add_result[WIDTH-1:0];
          end else begin
            result_d = c_q[WIDTH-1:0];
          end
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control, accumulator and result registers; reset aborts any operation
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      c_q      <= '0;
      i_q      <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      c_q      <= c_d;
      i_q      <= i_d;
      result_q <= result_d;
    end
  end

  // Latched operands; only meaningful once an operation has started
  always_ff @(posedge clk) begin
    a_q <= a_d;
    b_q <= b_d;
    m_q <= m_d;
  end

  assign bus.add_start    = add_start_s;
  assign bus.add_subtract = add_sub_s;
  assign bus.add_shift    = add_shift_s;
  assign bus.add_in_a     = c_q;
  assign bus.add_in_b     = add_in_b_s;
  assign bus.result       = result_q;
  assign bus.done         = (state_q == DONE);
  assign bus.busy         = (state_q != IDLE);

endmodule
